// File: rtl/arb_pkg.sv
// arb_pkg: shared types, sizes and the round-robin pick helper used by
// the arb8_mux16 arbiter and its Mux8Way16 data path.
package arb_pkg;

   localparam int N_REQ  = 8;
   localparam int W_DATA = 16;
   localparam int SEL_W  = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Scans requesters in the order ptr, ptr+1, ..., ptr+7 (mod 8) and
   // returns {found, idx} for the first one with its request bit set.
   // When nothing is requesting, found=0 and idx is simply ptr.
   function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [SEL_W-1:0] ptr);
      logic             found;
      logic [SEL_W-1:0] idx;
      logic [SEL_W-1:0] cand;
      found = 1'b0;
      idx   = ptr;
      for (int i = 0; i < N_REQ; i++) begin
         cand = ptr + SEL_W'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

endpackage

// File: rtl/arb8_mux16_mux8way16.sv
// Mux8Way16: purely combinational 8-to-1 selector of 16-bit words.
//   data_i : eight packed words, word k at [16k+15:16k]
//   sel_i  : index of the word to pass through
//   out_o  : selected word
module Mux8Way16
   import arb_pkg::*;
(
   input  logic [N_REQ*W_DATA-1:0] data_i,
   input  logic [SEL_W-1:0]        sel_i,
   output logic [W_DATA-1:0]       out_o
);

   // Indexed part-select picks word sel_i out of the packed bus.
   always_comb begin
      out_o = data_i[sel_i*W_DATA +: W_DATA];
   end

endmodule

// File: rtl/arb8_mux16.sv
// arb8_mux16: round-robin arbiter sharing one 16-bit output bus among
// eight requesters; each grant lasts up to BURST handshaked beats.
//   clk_i   : clock, all state changes on the rising edge
//   rst_n_i : synchronous active-low reset
//   req_i   : level-sensitive request per requester
//   data_i  : requester k word at [16k+15:16k]
//   ready_i : consumer accepts the current beat
//   gnt_o   : registered one-hot grant
//   sel_o   : registered index of the granted requester
//   valid_o : registered beat-valid
//   out_o   : selected word, zero whenever valid_o is low
module arb8_mux16
   import arb_pkg::*;
#(
   parameter int unsigned BURST = 1
)(
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic [N_REQ-1:0]        req_i,
   input  logic [N_REQ*W_DATA-1:0] data_i,
   input  logic                    ready_i,
   output logic [N_REQ-1:0]        gnt_o,
   output logic [SEL_W-1:0]        sel_o,
   output logic                    valid_o,
   output logic [W_DATA-1:0]       out_o
);

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic               valid_q, valid_d;
   logic [7:0]         cnt_q, cnt_d;

   logic [SEL_W:0]     pick_idle;
   logic [SEL_W:0]     pick_next;
   logic [SEL_W-1:0]   next_ptr;
   logic [8:0]         cnt_inc;
   logic               last_beat;
   logic               end_grant;
   logic [W_DATA-1:0]  mux_out;

   // Arbitration candidates: one from the resting pointer (used from IDLE)
   // and one from just past the current owner (used when a grant ends, so
   // the outgoing requester drops to lowest priority).
   always_comb begin
      next_ptr  = sel_q + 3'd1;
      pick_idle = rr_pick(req_i, ptr_q);
      pick_next = rr_pick(req_i, next_ptr);
      cnt_inc   = {1'b0, cnt_q} + 9'd1;
      last_beat = (cnt_inc == 9'(BURST));
   end

   // Next-state logic. A handshake takes precedence over a dropped request
   // in the same cycle, so the beat is still counted as accepted. Ending a
   // grant re-arbitrates immediately, giving back-to-back grants with no
   // idle cycle in between.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      valid_d   = valid_q;
      cnt_d     = cnt_q;
      end_grant = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_idle[SEL_W]) begin
               state_d = BUSY;
               sel_d   = pick_idle[SEL_W-1:0];
               gnt_d   = 8'd1 << pick_idle[SEL_W-1:0];
               valid_d = 1'b1;
               cnt_d   = 8'd0;
            end
         end
         BUSY: begin
            if (ready_i) begin
               if (last_beat) begin
                  end_grant = 1'b1;
               end else begin
                  cnt_d = cnt_inc[7:0];
               end
            end else if (!req_i[sel_q]) begin
               end_grant = 1'b1;
            end
            if (end_grant) begin
               ptr_d = next_ptr;
               cnt_d = 8'd0;
               if (pick_next[SEL_W]) begin
                  state_d = BUSY;
                  sel_d   = pick_next[SEL_W-1:0];
                  gnt_d   = 8'd1 << pick_next[SEL_W-1:0];
                  valid_d = 1'b1;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  valid_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // State registers; reset discards any grant in progress.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         sel_q   <= '0;
         ptr_q   <= '0;
         gnt_q   <= '0;
         valid_q <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   Mux8Way16 u_mux (
      .data_i (data_i),
      .sel_i  (sel_q),
      .out_o  (mux_out)
   );

   // Output bus is blanked when no beat is being offered.
   always_comb begin
      out_o = valid_q ? mux_out : '0;
   end

   assign gnt_o   = gnt_q;
   assign sel_o   = sel_q;
   assign valid_o = valid_q;

endmodule
